alu_issue_stage: RTL and testbench

//  Operand-fetch / issue / write-back stage placed directly upstream of the ALU.
//  - Holds an 8 x 16-bit register file.
//  - Accepts one instruction {op, rd, rs, rt, imm} per valid/ready handshake.
//  - Drives registered operands and opcode into the combinational ALU.
//  - Writes the ALU result back to rd. Multi-cycle and non-pipelined: one instruction in flight.

---
 rtl/alu_issue_if.sv | 46 ++++
 rtl/alu_issue_stage.sv | 176 +++++++++++++++++
 tb/tb_alu_issue_stage.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_if.sv
// ---------------------------------------------------------------------------
// alu_issue_if
// Purpose : bundles the instruction handshake, the ALU operand/result bus and
//           the status/debug signals of alu_issue_stage into one interface.
// Signals :
//   in_valid/in_ready             instruction handshake
//   in_op/in_rd/in_rs/in_rt/in_imm instruction fields
//   alu_a/alu_b/alu_op            registered operands and opcode to the ALU
//   alu_result                    combinational ALU output
//   done                          one-cycle retire pulse
//   illegal                       sticky illegal-opcode flag
//   dbg_addr/dbg_data             combinational register-file read port
// Modports: slave  - the issue stage
//           master - producer / ALU / debug side (the environment)
// ---------------------------------------------------------------------------
interface alu_issue_if #(
   parameter int DW  = 16,
   parameter int AW  = 3,
   parameter int OPW = 5
) ();
   logic           in_valid;
   logic           in_ready;
   logic [OPW-1:0] in_op;
   logic [AW-1:0]  in_rd;
   logic [AW-1:0]  in_rs;
   logic [AW-1:0]  in_rt;
   logic [DW-1:0]  in_imm;
   logic [DW-1:0]  alu_a;
   logic [DW-1:0]  alu_b;
   logic [OPW-1:0] alu_op;
   logic [DW-1:0]  alu_result;
   logic           done;
   logic           illegal;
   logic [AW-1:0]  dbg_addr;
   logic [DW-1:0]  dbg_data;

   modport slave (
      input  in_valid, in_op, in_rd, in_rs, in_rt, in_imm, alu_result, dbg_addr,
      output in_ready, alu_a, alu_b, alu_op, done, illegal, dbg_data
   );

   modport master (
      output in_valid, in_op, in_rd, in_rs, in_rt, in_imm, alu_result, dbg_addr,
      input  in_ready, alu_a, alu_b, alu_op, done, illegal, dbg_data
   );
endinterface

// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
// Purpose : operand-fetch / issue / write-back stage in front of a
//           combinational ALU. Holds a 2**AW x DW register file, accepts one
//           instruction per handshake, drives registered operands to the ALU
//           and writes the result back. One instruction in flight; three
//           cycles per instruction (IDLE -> EXEC -> DONE).
// Ports   :
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - alu_issue_if.slave (handshake, ALU bus, done/illegal, debug read)
// Opcodes : 0x00 NOP, 0x01 ADD, 0x02 SUB, 0x03 AND, 0x04 OR, 0x05 XOR,
//           0x06 NOR, 0x1F LDI; 0x07..0x1E are illegal (sticky flag).
// Config  : REG0_ZERO_EN - when defined, R[0] is hard-wired to zero
//           (writes discarded, done still pulses).
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | in_ready=1; handshake captures operands and decoded opcode
//   EXEC  | ALU operands valid; write-back of ALU result / imm at cycle end
//   DONE  | done=1; alu_op back to NOP; write-back visible on dbg_data
// ---------------------------------------------------------------------------
module alu_issue_stage #(
   parameter int DW  = 16,
   parameter int AW  = 3,
   parameter int OPW = 5
) (
   input  logic        clk,
   input  logic        rst,
   alu_issue_if.slave  bus
);

   localparam int NREG = 1 << AW;

   localparam logic [OPW-1:0] OP_NOP = OPW'(8'h00);
   localparam logic [OPW-1:0] OP_ADD = OPW'(8'h01);
   localparam logic [OPW-1:0] OP_NOR = OPW'(8'h06);
   localparam logic [OPW-1:0] OP_LDI = OPW'(8'h1F);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Write-back source chosen at issue so EXEC does not re-decode the opcode.
   typedef enum logic [1:0] {
      WB_NONE = 2'd0,
      WB_ALU  = 2'd1,
      WB_IMM  = 2'd2
   } wb_t;

   state_t         state_q, state_d;
   wb_t            wb_q,    wb_d;
   logic [DW-1:0]  rf_q [NREG];
   logic [DW-1:0]  rf_d [NREG];
   logic [DW-1:0]  alu_a_q,  alu_a_d;
   logic [DW-1:0]  alu_b_q,  alu_b_d;
   logic [OPW-1:0] alu_op_q, alu_op_d;
   logic [AW-1:0]  rd_q,     rd_d;
   logic [DW-1:0]  imm_q,    imm_d;
   logic           illegal_q, illegal_d;

   logic           handshake;
   logic           op_is_alu;
   logic           op_is_ldi;
   logic           op_is_nop;
   logic           rd_writable;

   assign handshake = bus.in_valid && (state_q == ST_IDLE);
   assign op_is_alu = (bus.in_op >= OP_ADD) && (bus.in_op <= OP_NOR);
   assign op_is_ldi = (bus.in_op == OP_LDI);
   assign op_is_nop = (bus.in_op == OP_NOP);

`ifdef REG0_ZERO_EN
   // R[0] never leaves its reset value, so every read of it returns zero.
   assign rd_writable = (rd_q != '0);
`else
   assign rd_writable = 1'b1;
`endif

   always_comb begin
      state_d   = state_q;
      wb_d      = wb_q;
      rf_d      = rf_q;
      alu_a_d   = alu_a_q;
      alu_b_d   = alu_b_q;
      alu_op_d  = alu_op_q;
      rd_d      = rd_q;
      imm_d     = imm_q;
      illegal_d = illegal_q;

      case (state_q)
         ST_IDLE: begin
            alu_op_d = OP_NOP;
            if (handshake) begin
               rd_d    = bus.in_rd;
               imm_d   = bus.in_imm;
               alu_a_d = rf_q[bus.in_rs];
               alu_b_d = rf_q[bus.in_rt];
               if (op_is_alu) begin
                  alu_op_d = bus.in_op;
                  wb_d     = WB_ALU;
               end else if (op_is_ldi) begin
                  wb_d     = WB_IMM;
               end else if (op_is_nop) begin
                  wb_d     = WB_NONE;
               end else begin
                  wb_d      = WB_NONE;
                  illegal_d = 1'b1;
               end
               state_d = ST_EXEC;
            end
         end

         ST_EXEC: begin
            if (rd_writable) begin
               if (wb_q == WB_ALU) begin
                  rf_d[rd_q] = bus.alu_result;
               end else if (wb_q == WB_IMM) begin
                  rf_d[rd_q] = imm_q;
               end
            end
            alu_op_d = OP_NOP;
            state_d  = ST_DONE;
         end

         ST_DONE: begin
            alu_op_d = OP_NOP;
            state_d  = ST_IDLE;
         end

         default: begin
            alu_op_d = OP_NOP;
            state_d  = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         wb_q      <= WB_NONE;
         alu_a_q   <= '0;
         alu_b_q   <= '0;
         alu_op_q  <= OP_NOP;
         rd_q      <= '0;
         imm_q     <= '0;
         illegal_q <= 1'b0;
         for (int i = 0; i < NREG; i++) begin
            rf_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         wb_q      <= wb_d;
         alu_a_q   <= alu_a_d;
         alu_b_q   <= alu_b_d;
         alu_op_q  <= alu_op_d;
         rd_q      <= rd_d;
         imm_q     <= imm_d;
         illegal_q <= illegal_d;
         for (int i = 0; i < NREG; i++) begin
            rf_q[i] <= rf_d[i];
         end
      end
   end

   assign bus.in_ready = (state_q == ST_IDLE);
   assign bus.done     = (state_q == ST_DONE);
   assign bus.alu_a    = alu_a_q;
   assign bus.alu_b    = alu_b_q;
   assign bus.alu_op   = alu_op_q;
   assign bus.illegal  = illegal_q;
   assign bus.dbg_data = rf_q[bus.dbg_addr];

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

   localparam int DW  = 16;
   localparam int AW  = 3;
   localparam int OPW = 5;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   alu_issue_if #(.DW(DW), .AW(AW), .OPW(OPW)) bus ();

   alu_issue_stage #(.DW(DW), .AW(AW), .OPW(OPW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational ALU seen by the stage.
   always_comb begin
      bus.alu_result = '0;
      case (bus.alu_op)
         5'h01: bus.alu_result = bus.alu_a + bus.alu_b;
         5'h02: bus.alu_result = bus.alu_a - bus.alu_b;
         5'h03: bus.alu_result = bus.alu_a & bus.alu_b;
         5'h04: bus.alu_result = bus.alu_a | bus.alu_b;
         5'h05: bus.alu_result = bus.alu_a ^ bus.alu_b;
         5'h06: bus.alu_result = ~(bus.alu_a | bus.alu_b);
         default: bus.alu_result = '0;
      endcase
   end

   // Reference model: architectural register file and sticky flag.
   logic [15:0] m_rf [8];
   bit          m_ill;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_rf[i] = 16'h0000;
      m_ill = 1'b0;
   endtask

   task automatic check_all_regs(input string tag);
      for (int i = 0; i < 8; i++) begin
         bus.dbg_addr = 3'(i);
         #1;
         chk($sformatf("%s_r%0d", tag, i), 32'(bus.dbg_data), 32'(m_rf[i]));
      end
   endtask

   // Issue one instruction (called at a negedge) and check every stage of it.
   task automatic issue(input logic [4:0] op, input logic [2:0] rd,
                        input logic [2:0] rs, input logic [2:0] rt,
                        input logic [15:0] imm);
      int          n;
      logic [15:0] ea, eb, res;
      logic [4:0]  eop;
      bit          wr;
      n = 0;
      while (!bus.in_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait", 32'(bus.in_ready), 32'd1);

      ea  = m_rf[rs];
      eb  = m_rf[rt];
      eop = 5'h00;
      wr  = 1'b1;
      res = 16'h0000;
      case (op)
         5'h01: begin eop = op; res = ea + eb;    end
         5'h02: begin eop = op; res = ea - eb;    end
         5'h03: begin eop = op; res = ea & eb;    end
         5'h04: begin eop = op; res = ea | eb;    end
         5'h05: begin eop = op; res = ea ^ eb;    end
         5'h06: begin eop = op; res = ~(ea | eb); end
         5'h1F: res = imm;
         5'h00: wr = 1'b0;
         default: begin wr = 1'b0; m_ill = 1'b1; end
      endcase
`ifdef REG0_ZERO_EN
      if (rd == 3'd0) wr = 1'b0;
`endif

      bus.in_op    = op;
      bus.in_rd    = rd;
      bus.in_rs    = rs;
      bus.in_rt    = rt;
      bus.in_imm   = imm;
      bus.dbg_addr = rd;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      bus.in_op  = 5'($urandom);
      bus.in_rs  = 3'($urandom);
      bus.in_rt  = 3'($urandom);
      bus.in_imm = 16'($urandom);
      @(negedge clk);
      chk("exec_alu_a",  32'(bus.alu_a),  32'(ea));
      chk("exec_alu_b",  32'(bus.alu_b),  32'(eb));
      chk("exec_alu_op", 32'(bus.alu_op), 32'(eop));
      chk("exec_ready",  32'(bus.in_ready), 32'd0);
      chk("exec_done",   32'(bus.done), 32'd0);
      if (wr) m_rf[rd] = res;
      @(negedge clk);
      chk("done_pulse",   32'(bus.done), 32'd1);
      chk("done_alu_op",  32'(bus.alu_op), 32'd0);
      chk("done_illegal", 32'(bus.illegal), 32'(m_ill));
      chk("done_wb",      32'(bus.dbg_data), 32'(m_rf[rd]));
      @(negedge clk);
      chk("idle_ready", 32'(bus.in_ready), 32'd1);
      chk("idle_done",  32'(bus.done), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          hs;
      logic [4:0]  op;
      checks   = 0;
      failures = 0;
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_op    = '0;
      bus.in_rd    = '0;
      bus.in_rs    = '0;
      bus.in_rt    = '0;
      bus.in_imm   = '0;
      bus.dbg_addr = '0;
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset state
      chk("rst_ready",   32'(bus.in_ready), 32'd1);
      chk("rst_done",    32'(bus.done), 32'd0);
      chk("rst_illegal", 32'(bus.illegal), 32'd0);
      chk("rst_alu_op",  32'(bus.alu_op), 32'd0);
      chk("rst_alu_a",   32'(bus.alu_a), 32'd0);
      chk("rst_alu_b",   32'(bus.alu_b), 32'd0);
      check_all_regs("rst");

      // Loads, add, wrap, subtract
      issue(5'h1F, 3'd1, 3'd0, 3'd0, 16'h0005);
      issue(5'h1F, 3'd2, 3'd0, 3'd0, 16'h0003);
      issue(5'h01, 3'd3, 3'd1, 3'd2, 16'h0000);
      chk("add_r3", 32'(m_rf[3]), 32'h0008);
      issue(5'h1F, 3'd4, 3'd0, 3'd0, 16'hFFFF);
      issue(5'h01, 3'd5, 3'd4, 3'd1, 16'h0000);
      issue(5'h02, 3'd6, 3'd2, 3'd1, 16'h0000);
      check_all_regs("dir");

      // Illegal opcode: flag set, no write, done still pulses
      issue(5'h09, 3'd1, 3'd2, 3'd3, 16'h7777);
      chk("illegal_set", 32'(bus.illegal), 32'd1);
      issue(5'h00, 3'd1, 3'd1, 3'd1, 16'h0000);
      chk("illegal_sticky", 32'(bus.illegal), 32'd1);

      // Back-to-back: in_valid held high, r1 = r1 + r1 twice
      bus.in_op    = 5'h01;
      bus.in_rd    = 3'd1;
      bus.in_rs    = 3'd1;
      bus.in_rt    = 3'd1;
      bus.dbg_addr = 3'd1;
      bus.in_valid = 1'b1;
      hs = 0;
      for (int c = 0; c < 6; c++) begin
         if (bus.in_valid && bus.in_ready) hs++;
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      m_rf[1] = m_rf[1] + m_rf[1];
      m_rf[1] = m_rf[1] + m_rf[1];
      chk("b2b_handshakes", 32'(hs), 32'd2);
      chk("b2b_r1", 32'(bus.dbg_data), 32'(m_rf[1]));
      @(negedge clk);

      // Randomized instructions against the model
      for (int k = 0; k < 40; k++) begin
         case ($urandom_range(0, 9))
            0:       op = 5'h00;
            1, 2:    op = 5'h1F;
            3:       op = 5'($urandom_range(7, 30));
            default: op = 5'($urandom_range(1, 6));
         endcase
         issue(op, 3'($urandom), 3'($urandom), 3'($urandom), 16'($urandom));
      end
      check_all_regs("rnd");

      // Reset during EXEC of ADD r7 = r1 + r2
      bus.in_op    = 5'h01;
      bus.in_rd    = 3'd7;
      bus.in_rs    = 3'd1;
      bus.in_rt    = 3'd2;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_exec", 32'(bus.in_ready), 32'd0);
      rst = 1'b1;
      #1;
      chk("async_rst_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      chk("post_rst_ready",   32'(bus.in_ready), 32'd1);
      chk("post_rst_illegal", 32'(bus.illegal), 32'd0);
      chk("post_rst_alu_op",  32'(bus.alu_op), 32'd0);
      chk("post_rst_alu_a",   32'(bus.alu_a), 32'd0);
      check_all_regs("post_rst");

      // R[0] write (hard-wired zero only when REG0_ZERO_EN is defined)
      issue(5'h1F, 3'd0, 3'd0, 3'd0, 16'h1234);
      issue(5'h1F, 3'd3, 3'd0, 3'd0, 16'h0042);
      issue(5'h01, 3'd4, 3'd0, 3'd3, 16'h0000);
      check_all_regs("r0");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
